line_buffer_3row: RTL
=====================

# line_buffer_3row

Upstream feeder for the 3x3 convolution stage. Accepts a raster-order pixel stream, one pixel per cycle with bubbles allowed, and stores the two previous image rows. Each accepted pixel produces one vertical 3-pixel column (rows r-2, r-1, r) and the convolution enable, which drive the convolution stage's three data inputs and its enable directly. Frame bookkeeping, priming and end-of-frame signalling are handled here.

## Interface
- `IMG_WIDTH`, default 64: pixels per row; must be ≥3.
- `IMG_HEIGHT`, default 64: rows per frame; must be ≥3.
- `NB_PIXEL`, default 8: pixel width, signed.
- `clk`, in, 1: clock, 100 MHz.
- `i_rst`, in, 1: reset; one clock; reset is synchronous and active-high.
- `i_valid`, in, 1: `i_pixel` is valid this cycle.
- `i_sof`, in, 1: start of frame; qualifies with `i_valid` and marks pixel (0,0).
- `i_pixel`, in, NB_PIXEL: input pixel, signed.
- `o_data1`, out, NB_PIXEL: pixel at (r-2, c), top row.
- `o_data2`, out, NB_PIXEL: pixel at (r-1, c).
- `o_data3`, out, NB_PIXEL: pixel at (r, c), current row.
- `o_en_conv`, out, 1: the column on `o_data1..3` is valid; the convolution stage shifts it in.
- `o_win_valid`, out, 1: this column completes a full 3x3 window (c ≥ 2).
- `o_eof`, out, 1: one-cycle pulse with the column of the last frame pixel.
- `o_drop`, out, 1: one-cycle pulse; a pixel was discarded.

## Operation
- State machine states: IDLE, PRIME, STREAM.
- IDLE:
  - `i_valid & i_sof` accepts the pixel as (0,0) and moves to PRIME.
  - `i_valid & !i_sof` discards the pixel and pulses `o_drop`.
- PRIME covers rows 0 and 1.
  - Pixels are written to line memory only.
  - `o_en_conv` stays 0.
  - At the end of row 1, move to STREAM.
- STREAM covers rows 2 .. IMG_HEIGHT-1.
  - Every accepted pixel asserts `o_en_conv`.
  - `o_win_valid` = `o_en_conv` & (c ≥ 2).
  - After the pixel (IMG_HEIGHT-1, IMG_WIDTH-1): pulse `o_eof` and return to IDLE.
- Counters:
  - Column counter c: 0..IMG_WIDTH-1, wraps to 0 and increments row counter r.
  - Row counter r: 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
- Line memories: LM_A holds row r-2, LM_B holds row r-1, each IMG_WIDTH x NB_PIXEL. For each accepted pixel at column c:
  - read LM_A[c] and LM_B[c] (read-before-write);
  - write LM_A[c] ← LM_B[c] and LM_B[c] ← `i_pixel`.
- Column mapping: `o_data1` = old LM_A[c], `o_data2` = old LM_B[c], `o_data3` = `i_pixel` (registered).
- No arithmetic. Pixels pass bit-exact as signed NB_PIXEL with no sign extension.
- `i_sof` with `i_valid` in PRIME or STREAM:
  - counters restart at (0,0), state goes to PRIME;
  - the pixel is accepted as (0,0);
  - `o_drop` pulses once for the truncated frame;
  - `o_eof` is not asserted.
- `i_sof` without `i_valid` is ignored in every state.
- Bubble (`i_valid`=0):
  - `o_en_conv`, `o_win_valid`, `o_eof` are 0;
  - `o_data1..3` hold their last values;
  - counters hold.
- Line memories are never cleared. Priming guarantees that no stale data reaches `o_en_conv`=1.

## Timing
- All outputs are registered. Latency is 1 clk from an accepted `i_pixel` to its column on `o_data1..3` / `o_en_conv`.
- Throughput is 1 pixel/clk with no back-pressure.
- Convolution result alignment: the window result appears on the convolution output 2 clk after the cycle `o_win_valid`=1.
- Reset (`i_rst`=1 at a rising edge):
  - state → IDLE, c=0, r=0;
  - all outputs → 0.
  - This takes effect immediately, including mid-frame. The next frame requires `i_sof`.
- `o_eof` coincides with the final `o_en_conv`=1 cycle of the frame.
- `o_drop` asserts 1 clk after the offending input.

## Structure
- Package `conv_pkg`: NB_PIXEL, KERNEL_SIZE=3, state enum (IDLE/PRIME/STREAM), pixel typedef. Shared with the convolution stage.
- Sub-module `line_ram`: single-port, read-first, IMG_WIDTH x W, synchronous write.
  - Instantiated once with W = 2·NB_PIXEL, holding {LM_A, LM_B} in one word.
  - Read data is used in the same cycle as address presentation (LUTRAM-style asynchronous read), so the 1-clk latency is preserved.

## Test plan
- Reset then 4x4 frame, IMG_WIDTH=4, IMG_HEIGHT=4, pixels 1..16 with sof on the first:
  - first `o_en_conv` carries (1,5,9);
  - `o_win_valid` first asserts on (3,7,11);
  - 8 enables in total, `o_eof` with (8,12,16).
- Same frame with `i_valid` toggling 1/0:
  - identical output column sequence;
  - `o_en_conv`=0 in every bubble cycle, data held.
- Pixels with no sof in IDLE: 3 pixels → 3 `o_drop` pulses, no `o_en_conv`.
- sof mid-row-2 of frame A, then full frame B (values 100..115):
  - 1 `o_drop`;
  - first enable after restart carries (100,104,108);
  - no `o_eof` for frame A.
- `i_rst` asserted during STREAM:
  - next cycle all outputs are 0 and state is IDLE;
  - a subsequent full frame reproduces the results of the first test.
- Signed extremes (-128, 127) pass unchanged on `o_data1..3`.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the line buffer and the 3x3 convolution stage
package conv_pkg;

    localparam int NB_PIXEL    = 8;
    localparam int KERNEL_SIZE = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PRIME  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    typedef logic signed [NB_PIXEL-1:0] pixel_t;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port read-first row memory with asynchronous read and synchronous write
module line_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Combinational read returns the pre-write word in the write cycle.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - two-row line buffer emitting vertical 3-pixel columns for the 3x3 convolution
module line_buffer_3row
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int NB_PIXEL   = conv_pkg::NB_PIXEL
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic signed [NB_PIXEL-1:0] i_pixel,
    output logic signed [NB_PIXEL-1:0] o_data1,
    output logic signed [NB_PIXEL-1:0] o_data2,
    output logic signed [NB_PIXEL-1:0] o_data3,
    output logic                       o_en_conv,
    output logic                       o_win_valid,
    output logic                       o_eof,
    output logic                       o_drop
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [NB_PIXEL-1:0]  data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;
    logic                 en_conv_q, en_conv_d, win_valid_q, win_valid_d;
    logic                 eof_q, eof_d, drop_q, drop_d;

    logic                 restart, accept, last_col;
    logic [CW-1:0]        pix_col;
    logic [RW-1:0]        pix_row;
    logic [2*NB_PIXEL-1:0] ram_rdata, ram_wdata;

    // One word holds {row r-2, row r-1} for a column, so a single access shifts both rows.
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .W     (2 * NB_PIXEL)
    ) u_line_ram (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign ram_wdata = {ram_rdata[NB_PIXEL-1:0], i_pixel};

    always_comb begin
        restart  = i_valid & i_sof;
        accept   = i_valid & (restart | (state_q != ST_IDLE));
        pix_col  = restart ? '0 : col_q;
        pix_row  = restart ? '0 : row_q;
        last_col = (pix_col == CW'(IMG_WIDTH - 1));

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        data3_d     = data3_q;
        en_conv_d   = accept & ~restart & (state_q == ST_STREAM);
        win_valid_d = en_conv_d & (pix_col >= CW'(2));
        eof_d       = en_conv_d & last_col & (pix_row == RW'(IMG_HEIGHT - 1));
        drop_d      = i_valid & (restart ? (state_q != ST_IDLE) : (state_q == ST_IDLE));

        if (accept) begin
            data1_d = ram_rdata[2*NB_PIXEL-1:NB_PIXEL];
            data2_d = ram_rdata[NB_PIXEL-1:0];
            data3_d = i_pixel;
            col_d   = last_col ? '0 : pix_col + CW'(1);
            row_d   = last_col ? pix_row + RW'(1) : pix_row;
            state_d = restart ? ST_PRIME : state_q;
            if (state_d == ST_PRIME && last_col && pix_row == RW'(1)) begin
                state_d = ST_STREAM;
            end
            if (eof_d) begin
                state_d = ST_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            data3_q     <= '0;
            en_conv_q   <= 1'b0;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            data3_q     <= data3_d;
            en_conv_q   <= en_conv_d;
            win_valid_q <= win_valid_d;
            eof_q       <= eof_d;
            drop_q      <= drop_d;
        end
    end

    assign o_data1     = data1_q;
    assign o_data2     = data2_q;
    assign o_data3     = data3_q;
    assign o_en_conv   = en_conv_q;
    assign o_win_valid = win_valid_q;
    assign o_eof       = eof_q;
    assign o_drop      = drop_q;

endmodule
